// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes,
// controller FSM states and the hard-wired zero register ID.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hz_state_e;

    localparam int unsigned R0 = 0;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Stage-ID / control-bit bundle between the 5-stage pipeline (master) and
// the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int REG_AW = 4
);
    logic [REG_AW-1:0] id_rs, id_rt;
    logic              id_uses_rs, id_uses_rt;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic              ex_regwrite, ex_memread, ex_is_mul, ex_branch_taken;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;

    logic              pc_write, pc_sel_branch;
    logic              ifid_write, idex_write;
    logic              idex_bubble, exmem_bubble;
    logic              ifid_flush, idex_flush;
    logic [1:0]        fwd_a, fwd_b;
    logic              mul_busy;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_valid, ex_rs, ex_rt, ex_rd,
               ex_regwrite, ex_memread, ex_is_mul, ex_branch_taken,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  pc_write, pc_sel_branch, ifid_write, idex_write, idex_bubble,
               exmem_bubble, ifid_flush, idex_flush, fwd_a, fwd_b, mul_busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_valid, ex_rs, ex_rt, ex_rd,
               ex_regwrite, ex_memread, ex_is_mul, ex_branch_taken,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output pc_write, pc_sel_branch, ifid_write, idex_write, idex_bubble,
               exmem_bubble, ifid_flush, idex_flush, fwd_a, fwd_b, mul_busy
    );
endinterface

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Forward-source select for one EX operand; EX/MEM wins over MEM/WB.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int R0_ZERO = 1
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    output fwd_sel_e          sel_o
);
    localparam logic [REG_AW-1:0] R0_ID = REG_AW'(R0);

    logic src_live, mem_hit, wb_hit;

    // A hard-wired zero source never needs a forwarded value.
    assign src_live = (R0_ZERO == 0) || (src_i != R0_ID);
    assign mem_hit  = mem_regwrite_i && (mem_rd_i == src_i) && src_live;
    assign wb_hit   = wb_regwrite_i && (wb_rd_i == src_i) && src_live;

    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit)     sel_o = FWD_MEM;
        else if (wb_hit) sel_o = FWD_WB;
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush and
// MUL freeze. Define HAZARD_CTRL_PERF_CNT_EN to add saturating perf counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int MUL_LAT = 4,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_mul_cycles,
    output logic [CNT_W-1:0] perf_flushes
`endif
);
    localparam int                CW        = 4;
    localparam logic [CW-1:0]     WAIT_LOAD = CW'(MUL_LAT - 2);
    localparam bit                HAS_WAIT  = (MUL_LAT > 2);
    localparam logic [REG_AW-1:0] R0_ID     = REG_AW'(R0);

    hz_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mul_done_q, mul_done_d;

    logic     pc_write, pc_sel_branch, ifid_write, idex_write;
    logic     idex_bubble, exmem_bubble, ifid_flush, idex_flush, mul_busy;
    logic     lu_hit, mul_start;
    fwd_sel_e fwd_a_sel, fwd_b_sel;

    function automatic logic id_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && ((R0_ZERO == 0) || (a != R0_ID));
    endfunction

    assign lu_hit = hz.ex_valid && hz.ex_memread && hz.ex_regwrite &&
                    ((hz.id_uses_rs && id_match(hz.ex_rd, hz.id_rs)) ||
                     (hz.id_uses_rt && id_match(hz.ex_rd, hz.id_rt)));

    // The MUL still sits in EX during the release cycle; mul_done_q stops it
    // from re-triggering the freeze while EX/MEM captures its result.
    assign mul_start = (state_q == RUN) && hz.ex_valid && hz.ex_is_mul && !mul_done_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mul_done_d    = 1'b0;
        pc_write      = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_write    = 1'b1;
        idex_write    = 1'b1;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        mul_busy      = 1'b0;
        case (state_q)
            RUN: begin
                if (mul_start) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    if (HAS_WAIT) begin
                        state_d = MUL_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        mul_done_d = 1'b1;
                    end
                end else if (hz.ex_branch_taken) begin
                    pc_sel_branch = 1'b1;
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                end else if (lu_hit) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MUL_WAIT: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                mul_busy     = 1'b1;
                cnt_d        = cnt_q - 1'b1;
                // Counter reaches zero on this edge: next cycle is the release.
                if (cnt_q <= CW'(1)) begin
                    state_d    = RUN;
                    mul_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            mul_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_done_q <= mul_done_d;
        end
    end

    fwd_select #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_fwd_a (
        .src_i         (hz.ex_rs),
        .mem_rd_i      (hz.mem_rd),
        .mem_regwrite_i(hz.mem_regwrite),
        .wb_rd_i       (hz.wb_rd),
        .wb_regwrite_i (hz.wb_regwrite),
        .sel_o         (fwd_a_sel)
    );

    fwd_select #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_fwd_b (
        .src_i         (hz.ex_rt),
        .mem_rd_i      (hz.mem_rd),
        .mem_regwrite_i(hz.mem_regwrite),
        .wb_rd_i       (hz.wb_rd),
        .wb_regwrite_i (hz.wb_regwrite),
        .sel_o         (fwd_b_sel)
    );

    assign hz.pc_write      = pc_write;
    assign hz.pc_sel_branch = pc_sel_branch;
    assign hz.ifid_write    = ifid_write;
    assign hz.idex_write    = idex_write;
    assign hz.idex_bubble   = idex_bubble;
    assign hz.exmem_bubble  = exmem_bubble;
    assign hz.ifid_flush    = ifid_flush;
    assign hz.idex_flush    = idex_flush;
    assign hz.fwd_a         = fwd_a_sel;
    assign hz.fwd_b         = fwd_b_sel;
    assign hz.mul_busy      = mul_busy;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, mul_cnt_q, fl_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt_q  <= '0;
            mul_cnt_q <= '0;
            fl_cnt_q  <= '0;
        end else begin
            if (idex_bubble && (lu_cnt_q != '1))   lu_cnt_q  <= lu_cnt_q + CNT_W'(1);
            if (exmem_bubble && (mul_cnt_q != '1)) mul_cnt_q <= mul_cnt_q + CNT_W'(1);
            if (ifid_flush && (fl_cnt_q != '1))    fl_cnt_q  <= fl_cnt_q + CNT_W'(1);
        end
    end

    assign perf_lu_stalls  = lu_cnt_q;
    assign perf_mul_cycles = mul_cnt_q;
    assign perf_flushes    = fl_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed table, MUL/reset sequences and random
// traffic against a cycle-level model; two instances (R0_ZERO = 1 and 0).
module tb_hazard_ctrl_unit;
    localparam int MUL_LAT = 4;

    typedef struct packed {
        logic [3:0] id_rs, id_rt;
        logic       id_uses_rs, id_uses_rt, ex_valid;
        logic [3:0] ex_rs, ex_rt, ex_rd;
        logic       ex_regwrite, ex_memread, ex_is_mul, ex_branch_taken;
        logic [3:0] mem_rd;
        logic       mem_regwrite;
        logic [3:0] wb_rd;
        logic       wb_regwrite;
    } in_t;

    typedef struct packed {
        logic       pc_write, pc_sel_branch, ifid_write, idex_write;
        logic       idex_bubble, exmem_bubble, ifid_flush, idex_flush;
        logic [1:0] fwd_a, fwd_b;
        logic       mul_busy;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    in_t  cur;
    out_t act_w, act0_w;

    hazard_ctrl_if #(.REG_AW(4)) hif ();
    hazard_ctrl_if #(.REG_AW(4)) hif0 ();

    assign {hif.id_rs, hif.id_rt, hif.id_uses_rs, hif.id_uses_rt, hif.ex_valid, hif.ex_rs,
            hif.ex_rt, hif.ex_rd, hif.ex_regwrite, hif.ex_memread, hif.ex_is_mul,
            hif.ex_branch_taken, hif.mem_rd, hif.mem_regwrite, hif.wb_rd, hif.wb_regwrite} = cur;
    assign {hif0.id_rs, hif0.id_rt, hif0.id_uses_rs, hif0.id_uses_rt, hif0.ex_valid, hif0.ex_rs,
            hif0.ex_rt, hif0.ex_rd, hif0.ex_regwrite, hif0.ex_memread, hif0.ex_is_mul,
            hif0.ex_branch_taken, hif0.mem_rd, hif0.mem_regwrite, hif0.wb_rd, hif0.wb_regwrite} = cur;
    assign act_w = {hif.pc_write, hif.pc_sel_branch, hif.ifid_write, hif.idex_write,
                    hif.idex_bubble, hif.exmem_bubble, hif.ifid_flush, hif.idex_flush,
                    hif.fwd_a, hif.fwd_b, hif.mul_busy};
    assign act0_w = {hif0.pc_write, hif0.pc_sel_branch, hif0.ifid_write, hif0.idex_write,
                     hif0.idex_bubble, hif0.exmem_bubble, hif0.ifid_flush, hif0.idex_flush,
                     hif0.fwd_a, hif0.fwd_b, hif0.mul_busy};

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] p_lu, p_mul, p_fl, p0_lu, p0_mul, p0_fl;
    hazard_ctrl_unit #(.REG_AW(4), .MUL_LAT(MUL_LAT), .R0_ZERO(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .hz(hif),
        .perf_lu_stalls(p_lu), .perf_mul_cycles(p_mul), .perf_flushes(p_fl));
    hazard_ctrl_unit #(.REG_AW(4), .MUL_LAT(MUL_LAT), .R0_ZERO(0), .CNT_W(32)) dut_nz (
        .clk(clk), .reset(reset), .hz(hif0),
        .perf_lu_stalls(p0_lu), .perf_mul_cycles(p0_mul), .perf_flushes(p0_fl));
`else
    hazard_ctrl_unit #(.REG_AW(4), .MUL_LAT(MUL_LAT), .R0_ZERO(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .hz(hif));
    hazard_ctrl_unit #(.REG_AW(4), .MUL_LAT(MUL_LAT), .R0_ZERO(0), .CNT_W(32)) dut_nz (
        .clk(clk), .reset(reset), .hz(hif0));
`endif

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: frozen cycles still owed by an accepted MUL, plus release flag.
    int          m_left = 0;
    bit          m_rel  = 1'b0;
    int unsigned m_lu = 0, m_mul = 0, m_fl = 0;

    function automatic out_t o_run(input logic [1:0] fa, input logic [1:0] fb);
        out_t o = '0;
        o.pc_write = 1'b1; o.ifid_write = 1'b1; o.idex_write = 1'b1;
        o.fwd_a = fa; o.fwd_b = fb;
        return o;
    endfunction

    function automatic out_t o_lu(input logic [1:0] fa, input logic [1:0] fb);
        out_t o = o_run(fa, fb);
        o.pc_write = 1'b0; o.ifid_write = 1'b0; o.idex_bubble = 1'b1;
        return o;
    endfunction

    function automatic out_t o_br(input logic [1:0] fa, input logic [1:0] fb);
        out_t o = o_run(fa, fb);
        o.pc_sel_branch = 1'b1; o.ifid_flush = 1'b1; o.idex_flush = 1'b1;
        return o;
    endfunction

    function automatic out_t o_frz(input logic [1:0] fa, input logic [1:0] fb, input logic busy);
        out_t o = '0;
        o.exmem_bubble = 1'b1; o.fwd_a = fa; o.fwd_b = fb; o.mul_busy = busy;
        return o;
    endfunction

    function automatic bit hit(input logic [3:0] a, input logic [3:0] b, input bit r0z);
        return (a == b) && (!r0z || a != 4'd0);
    endfunction

    function automatic out_t model_out(input in_t v, input bit r0z);
        logic [1:0] fa, fb;
        bit wait_c, entry, lu;
        fa = (v.mem_regwrite && hit(v.mem_rd, v.ex_rs, r0z)) ? 2'b10 :
             (v.wb_regwrite && hit(v.wb_rd, v.ex_rs, r0z)) ? 2'b01 : 2'b00;
        fb = (v.mem_regwrite && hit(v.mem_rd, v.ex_rt, r0z)) ? 2'b10 :
             (v.wb_regwrite && hit(v.wb_rd, v.ex_rt, r0z)) ? 2'b01 : 2'b00;
        wait_c = (m_left > 0);
        entry  = !wait_c && v.ex_valid && v.ex_is_mul && !m_rel;
        lu = v.ex_valid && v.ex_memread && v.ex_regwrite &&
             ((v.id_uses_rs && hit(v.ex_rd, v.id_rs, r0z)) ||
              (v.id_uses_rt && hit(v.ex_rd, v.id_rt, r0z)));
        if (wait_c || entry)      return o_frz(fa, fb, wait_c);
        if (v.ex_branch_taken)    return o_br(fa, fb);
        if (lu)                   return o_lu(fa, fb);
        return o_run(fa, fb);
    endfunction

    task automatic model_tick(input in_t v, input bit r);
        out_t o = model_out(v, 1'b1);
        if (r) begin
            m_left = 0; m_rel = 1'b0; m_lu = 0; m_mul = 0; m_fl = 0;
        end else begin
            if (o.idex_bubble)  m_lu++;
            if (o.exmem_bubble) m_mul++;
            if (o.ifid_flush)   m_fl++;
            if (m_left > 0) begin
                m_left--;
                m_rel = (m_left == 0);
            end else if (o.exmem_bubble) begin
                m_left = MUL_LAT - 2;
                m_rel  = (MUL_LAT == 2);
            end else begin
                m_rel = 1'b0;
            end
        end
    endtask

    // Drive one cycle; sample at negedge, model advances at the posedge.
    task automatic step(input in_t v, input bit r, output out_t a, output out_t a0,
                        output out_t e, output out_t e0);
        cur = v; reset = r;
        @(negedge clk);
        a = act_w; a0 = act0_w;
        e = model_out(v, 1'b1); e0 = model_out(v, 1'b0);
        @(posedge clk);
        model_tick(v, r);
        #1;
    endtask

    task automatic check(input string nm, input out_t a, input out_t e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    vec_t tbl[$];

    task automatic add(input string nm, input in_t i, input out_t o);
        vec_t v;
        v.name = nm; v.i = i; v.o = o;
        tbl.push_back(v);
    endtask

    initial begin
        in_t  t, lu_v;
        out_t a, a0, e, e0;

        t = '0;
        add("idle", t, o_run(2'b00, 2'b00));
        t.mem_rd = 3; t.mem_regwrite = 1; t.wb_rd = 3; t.wb_regwrite = 1; t.ex_rs = 3;
        add("fwd_mem_prio", t, o_run(2'b10, 2'b00));
        t.mem_regwrite = 0;
        add("fwd_wb", t, o_run(2'b01, 2'b00));
        t = '0; t.ex_rs = 2; t.ex_rt = 7; t.mem_rd = 7; t.mem_regwrite = 1; t.wb_rd = 7; t.wb_regwrite = 1;
        add("fwd_b_mem", t, o_run(2'b00, 2'b10));
        t = '0; t.ex_rs = 6; t.ex_rt = 6; t.wb_rd = 6; t.wb_regwrite = 1; t.mem_rd = 5; t.mem_regwrite = 1;
        add("fwd_wb_both", t, o_run(2'b01, 2'b01));
        t = '0; t.mem_regwrite = 1; t.wb_regwrite = 1; t.ex_valid = 1; t.ex_memread = 1;
        t.ex_regwrite = 1; t.id_uses_rs = 1;
        add("r0_suppress", t, o_run(2'b00, 2'b00));
        lu_v = '0; lu_v.ex_valid = 1; lu_v.ex_memread = 1; lu_v.ex_regwrite = 1;
        lu_v.ex_rd = 5; lu_v.id_rs = 5; lu_v.id_uses_rs = 1;
        add("lu_rs", lu_v, o_lu(2'b00, 2'b00));
        t = lu_v; t.id_uses_rs = 0; t.ex_rd = 9; t.id_rt = 9; t.id_uses_rt = 1;
        add("lu_rt", t, o_lu(2'b00, 2'b00));
        t.id_uses_rt = 0;
        add("lu_unused_src", t, o_run(2'b00, 2'b00));
        t = lu_v; t.ex_regwrite = 0;
        add("lu_no_regwrite", t, o_run(2'b00, 2'b00));
        t = lu_v; t.ex_valid = 0;
        add("lu_ex_invalid", t, o_run(2'b00, 2'b00));
        t = lu_v; t.ex_branch_taken = 1;
        add("branch_over_lu", t, o_br(2'b00, 2'b00));

        step('0, 1'b1, a, a0, e, e0);
        step('0, 1'b1, a, a0, e, e0);
        step('0, 1'b0, a, a0, e, e0);
        check("reset_state", a, o_run(2'b00, 2'b00));

        foreach (tbl[k]) begin
            step(tbl[k].i, 1'b0, a, a0, e, e0);
            check(tbl[k].name, a, tbl[k].o);
            if (tbl[k].name == "r0_suppress")
                check("r0_live_dut", a0, o_lu(2'b10, 2'b10));
        end

        // Load-use held one cycle, then the load leaves EX.
        step(lu_v, 1'b0, a, a0, e, e0);
        check("lu_seq_stall", a, o_lu(2'b00, 2'b00));
        t = lu_v; t.ex_valid = 0;
        step(t, 1'b0, a, a0, e, e0);
        check("lu_seq_release", a, o_run(2'b00, 2'b00));

        // MUL freeze: entry + two wait cycles, release on the fourth.
        t = '0; t.ex_valid = 1; t.ex_is_mul = 1; t.ex_rs = 4;
        step(t, 1'b0, a, a0, e, e0);
        check("mul_entry", a, o_frz(2'b00, 2'b00, 1'b0));
        t.mem_rd = 4; t.mem_regwrite = 1;
        step(t, 1'b0, a, a0, e, e0);
        check("mul_wait1_fwd", a, o_frz(2'b10, 2'b00, 1'b1));
        t.ex_branch_taken = 1;
        step(t, 1'b0, a, a0, e, e0);
        check("mul_branch_ignored", a, o_frz(2'b10, 2'b00, 1'b1));
        t.ex_branch_taken = 0; t.mem_regwrite = 0;
        step(t, 1'b0, a, a0, e, e0);
        check("mul_release", a, o_run(2'b00, 2'b00));
        t = '0;
        step(t, 1'b0, a, a0, e, e0);
        check("mul_after", a, o_run(2'b00, 2'b00));

        for (int c = 0; c < 600; c++) begin
            t.id_rs = 4'($urandom_range(0, 3));
            t.id_rt = 4'($urandom_range(0, 3));
            t.id_uses_rs = 1'($urandom_range(0, 1));
            t.id_uses_rt = 1'($urandom_range(0, 1));
            t.ex_valid = ($urandom_range(0, 3) != 0);
            t.ex_rs = 4'($urandom_range(0, 3));
            t.ex_rt = 4'($urandom_range(0, 3));
            t.ex_rd = 4'($urandom_range(0, 3));
            t.ex_regwrite = 1'($urandom_range(0, 1));
            t.ex_memread = 1'($urandom_range(0, 1));
            t.ex_is_mul = ($urandom_range(0, 7) == 0);
            t.ex_branch_taken = ($urandom_range(0, 5) == 0);
            t.mem_rd = 4'($urandom_range(0, 3));
            t.mem_regwrite = 1'($urandom_range(0, 1));
            t.wb_rd = 4'($urandom_range(0, 3));
            t.wb_regwrite = 1'($urandom_range(0, 1));
            step(t, ($urandom_range(0, 63) == 0), a, a0, e, e0);
            check("rand_r0z1", a, e);
            check("rand_r0z0", a0, e0);
        end

`ifdef HAZARD_CTRL_PERF_CNT_EN
        check32("perf_lu", p_lu, m_lu);
        check32("perf_mul", p_mul, m_mul);
        check32("perf_fl", p_fl, m_fl);
`endif

        // Reset during the second MUL_WAIT cycle.
        step('0, 1'b1, a, a0, e, e0);
        t = '0; t.ex_valid = 1; t.ex_is_mul = 1;
        step(t, 1'b0, a, a0, e, e0);
        step(t, 1'b0, a, a0, e, e0);
        check("rst_mul_wait1", a, o_frz(2'b00, 2'b00, 1'b1));
        step(t, 1'b1, a, a0, e, e0);
        check("rst_mul_wait2", a, o_frz(2'b00, 2'b00, 1'b1));
        step('0, 1'b0, a, a0, e, e0);
        check("rst_mul_after", a, o_run(2'b00, 2'b00));
`ifdef HAZARD_CTRL_PERF_CNT_EN
        check32("rst_perf_lu", p_lu, 32'd0);
        check32("rst_perf_mul", p_mul, 32'd0);
        check32("rst_perf_fl", p_fl, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
